// File: rtl/t_latch_pkg.sv
// rtl/t_latch_pkg.sv - shared definitions for the T latch codebase
//
// Purpose: FSM state encodings for the button debouncer, plus the default
//          debounce length that the downstream latch bench also uses.
// Ports:   none (package).

package t_latch_pkg;

  // Default number of consecutive synchronized samples needed to accept a level change.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

  // Debouncer states: the two IDLE states hold a stable level, and the two WAIT
  // states count a candidate transition toward the opposite level.
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } debounce_state_t;

endpackage : t_latch_pkg

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchronizer for one asynchronous input
//
// Purpose: brings an asynchronous level into the clk domain through
//          SYNC_STAGES flops. This module is reused for every asynchronous input.
// Ports:
//   clk  in  1  rising-edge clock
//   rst  in  1  synchronous active-high reset; clears every stage
//   d    in  1  asynchronous input level
//   q    out 1  synchronized level (last stage)

module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Stage 0 captures the raw input; each later stage copies the one before it.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule : sync_chain

// File: rtl/t_toggle_pulse_gen.sv
// rtl/t_toggle_pulse_gen.sv - debounced push-button to single-cycle T pulse
//
// Purpose: synchronizes a bouncy button and debounces it with a
//          consecutive-sample counter. It emits one T pulse on each accepted
//          rising transition. Releases change stable_level but never pulse T.
// Ports:
//   clk           in  1  rising-edge clock
//   rst           in  1  synchronous active-high reset
//   btn_in        in  1  raw asynchronous button level
//   T             out 1  registered single-cycle toggle request
//   stable_level  out 1  registered debounced button level
//   busy          out 1  registered; high while a candidate transition is counted

module t_toggle_pulse_gen
  import t_latch_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic T,
  output logic stable_level,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic s;

  debounce_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             t_q, t_d;
  logic             stable_q, stable_d;
  logic             busy_q, busy_d;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_in),
    .q  (s)
  );

  // The first differing sample already counts as one, so entering a WAIT state
  // loads cnt with 1. Acceptance happens on sample DEBOUNCE_CYCLES.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    t_d      = 1'b0;
    stable_d = stable_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
          busy_d  = 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = IDLE_HIGH;
          stable_d = 1'b1;
          t_d      = 1'b1;
          cnt_d    = '0;
          busy_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
          busy_d  = 1'b1;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          // Accepting a release updates the level only; T is never pulsed here.
          state_d  = IDLE_LOW;
          stable_d = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d  = IDLE_LOW;
        cnt_d    = '0;
        stable_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE_LOW;
      cnt_q    <= '0;
      t_q      <= 1'b0;
      stable_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      t_q      <= t_d;
      stable_q <= stable_d;
      busy_q   <= busy_d;
    end
  end

  assign T            = t_q;
  assign stable_level = stable_q;
  assign busy         = busy_q;

endmodule : t_toggle_pulse_gen

// File: tb/tb_t_toggle_pulse_gen.sv
// tb/tb_t_toggle_pulse_gen.sv - scoreboard bench for t_toggle_pulse_gen

module tb_t_toggle_pulse_gen;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic T, stable_level, busy;

  always #5 clk = ~clk;

  t_toggle_pulse_gen #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .T           (T),
    .stable_level(stable_level),
    .busy        (busy)
  );

  typedef struct packed {
    logic t;
    logic lvl;
    logic bsy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   t_seen = 0;
  int   seg_base = 0;

  // Reference model: the button value that the debouncer sees at an edge is the
  // one sampled SYNC edges earlier. That value is 0 if a reset edge occurred in
  // between. A level change is accepted after DEB consecutive samples that
  // differ from the current stable level.
  logic m_dly[SYNC];
  logic m_stable = 1'b0;
  int   m_run = 0;

  task automatic chk(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, expv);
    end
  endtask

  task automatic model_step(input logic b, input logic r);
    exp_t e;
    logic s;
    e.t = 1'b0;
    if (r) begin
      for (int i = 0; i < SYNC; i++) m_dly[i] = 1'b0;
      m_stable = 1'b0;
      m_run    = 0;
    end else begin
      s = m_dly[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) m_dly[i] = m_dly[i-1];
      m_dly[0] = b;
      if (s != m_stable) begin
        m_run++;
        if (m_run == DEB) begin
          m_stable = s;
          m_run    = 0;
          e.t      = s;
        end
      end else begin
        m_run = 0;
      end
    end
    e.lvl = m_stable;
    e.bsy = (m_run > 0);
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic b, input logic r);
    btn_in = b;
    rst    = r;
    @(posedge clk);
    model_step(b, r);
    @(negedge clk);
  endtask

  task automatic seg_pulses(input string name, input int expected);
    #1;
    checks++;
    if (t_seen - seg_base != expected) begin
      errors++;
      $display("FAIL pulses_%s: got %0d expected %0d", name, t_seen - seg_base, expected);
    end
    seg_base = t_seen;
  endtask

  // Monitor: compare the DUT outputs against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("T", T, e.t);
        chk("stable_level", stable_level, e.lvl);
        chk("busy", busy, e.bsy);
        if (T === 1'b1) t_seen++;
      end
    end
  end

  initial begin
    logic lvl;
    int   len;
    for (int i = 0; i < SYNC; i++) m_dly[i] = 1'b0;
    @(negedge clk);

    // Reset and idle
    repeat (3) cycle(1'b0, 1'b1);
    repeat (5) cycle(1'b0, 1'b0);
    seg_pulses("reset_idle", 0);

    // Clean press, then release
    repeat (12) cycle(1'b1, 1'b0);
    seg_pulses("clean_press", 1);
    repeat (10) cycle(1'b0, 1'b0);
    seg_pulses("release", 0);

    // Glitch shorter than the debounce length
    repeat (2) cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0);
    seg_pulses("glitch", 0);

    // Bouncing press
    begin
      logic [9:0] pat;
      pat = 10'b1111101101;
      for (int i = 0; i < 10; i++) cycle(pat[i], 1'b0);
    end
    repeat (6) cycle(1'b1, 1'b0);
    seg_pulses("bounce", 1);
    repeat (10) cycle(1'b0, 1'b0);
    seg_pulses("bounce_release", 0);

    // Reset while a candidate is being counted, with the button held through release
    repeat (4) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    repeat (10) cycle(1'b1, 1'b0);
    seg_pulses("reset_midcount", 1);
    repeat (10) cycle(1'b0, 1'b0);
    seg_pulses("post_reset_release", 0);

    // Random runs of bouncy levels with occasional resets
    lvl = 1'b0;
    for (int r = 0; r < 300; r++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        cycle(lvl, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
      end
    end
    repeat (10) cycle(1'b0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_t_toggle_pulse_gen

// File: doc/t_toggle_pulse_gen.md
# t_toggle_pulse_gen

Upstream driver for the T latch stage: takes a raw, bouncy, asynchronous push-button level and produces a clean, single-cycle toggle request `T` per debounced press. It synchronizes the input, debounces it with a consecutive-sample counter, and emits exactly one `T` pulse on each accepted low-to-high transition. Releases never generate a pulse. The `T` output connects directly to the T input of the downstream toggle stage.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops on `btn_in`. Legal range is 2 or more.
- `DEBOUNCE_CYCLES`, default 4: number of consecutive synchronized samples needed to accept a level change. Legal range is 2 or more.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)+1`: debounce counter width. Derived; do not override.
- `clk`  input  1  sole clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `btn_in`  input  1  raw asynchronous button level.
- `T`  output  1  registered single-cycle toggle request.
- `stable_level`  output  1  registered debounced button level.
- `busy`  output  1  registered; high while a candidate transition is being counted.

## Operation
- Synchronizer: `btn_in` passes through `SYNC_STAGES` flops. The last flop output is `s`.
- The FSM has four states:
  - `IDLE_LOW` (stable 0)
  - `WAIT_HIGH` (counting 1s)
  - `IDLE_HIGH` (stable 1)
  - `WAIT_LOW` (counting 0s)
- `IDLE_LOW`:
  - `s=1`: go to `WAIT_HIGH`, cnt←1, busy←1.
  - `s=0`: stay.
- `WAIT_HIGH`:
  - `s=0`: go to `IDLE_LOW`, cnt←0, busy←0. The candidate is discarded as a glitch.
  - `s=1` and cnt==DEBOUNCE_CYCLES-1: go to `IDLE_HIGH`, stable_level←1, T←1, cnt←0, busy←0.
  - `s=1` otherwise: cnt←cnt+1.
- `IDLE_HIGH`:
  - `s=0`: go to `WAIT_LOW`, cnt←1, busy←1.
  - `s=1`: stay.
- `WAIT_LOW` mirrors `WAIT_HIGH` with polarities inverted. On acceptance: go to `IDLE_LOW`, stable_level←0, **no T pulse**.
- `T` defaults to 0 every cycle. It is 1 only in the single cycle following acceptance of a rising transition.
- Counter arithmetic is unsigned and never exceeds `DEBOUNCE_CYCLES-1`, so no wrap is possible.
- Reset, applied in any state including mid-count:
  - state←`IDLE_LOW`, all sync flops←0, cnt←0.
  - T←0, stable_level←0, busy←0.
  - Any pending candidate is lost and no pulse is issued.
- A button held high through reset release counts as a fresh press. It produces one T pulse after the full latency below.

## Timing
- Reset values: T=0, stable_level=0, busy=0.
- Press latency:
  - `btn_in` first sampled high at edge k.
  - `s` is high after edge k+SYNC_STAGES-1.
  - `busy` rises at edge k+SYNC_STAGES.
  - T and stable_level rise at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. With defaults this is k+5.
  - T falls one edge later.
- Release latency is identical for stable_level and busy. T stays 0.
- Glitch rejection: a synchronized pulse shorter than DEBOUNCE_CYCLES cycles produces no T and no stable_level change. busy returns to 0 on the edge after `s` returns.
- Minimum spacing between T pulses: 2×DEBOUNCE_CYCLES cycles (press + release + press).
- No combinational path from any input to any output.

## Structure
- Shared package `t_latch_pkg` holds:
  - FSM state encodings: `IDLE_LOW`=2'b00, `WAIT_HIGH`=2'b01, `IDLE_HIGH`=2'b10, `WAIT_LOW`=2'b11.
  - The default `DEBOUNCE_CYCLES` constant, reused by the downstream latch bench.
- One sub-module, `sync_chain`: parameterized `SYNC_STAGES` flop chain with `clk` and `rst` ports. It is reused for every asynchronous input in the codebase.
- Top level contains the FSM, the counter and the output registers.

## Test plan
- Reset/idle: assert rst for 3 cycles with btn_in=0 → T=0, stable_level=0, busy=0 throughout and after release.
- Clean press: btn_in 0→1 at edge 10 and held, defaults → busy=1 at edge 12, T=1 only between edges 15–16, stable_level=1 from edge 15.
- Glitch: btn_in high for 2 cycles, then low → T never 1, stable_level stays 0, busy high for 2 cycles then 0.
- Bounce: btn_in pattern 1,0,1,1,0,1,1,1,1,1 (then held) → exactly one T pulse, 5 edges after the final 0→1 is sampled.
- Release: from stable high, btn_in→0 held for 10 cycles → stable_level=0 at edge k+5, no T pulse; a following clean press yields one T pulse.
- Reset mid-count: rst asserted while busy=1 with cnt=2 → next cycle all outputs 0 and state `IDLE_LOW`; holding btn_in high after release yields one T at rst-deassert edge + 5.
